logic_bist_ctrl: RTL

//  Built-in self-test sequencer for the 2-input bitwise logic gates (AND/OR/XOR/XNOR).
//  On start it drives every operand/opcode vector into the gate under test (DUT).
//  It waits a settle time, then compares the DUT output with an internal golden model.
//  It counts mismatches and reports pass/fail; it is the on-chip replacement for hand-written gate benches.

---
 rtl/logic_bist_if.sv | 26 ++
 rtl/logic_bist_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_bist_if.sv
// Handshake and gate-under-test bus between the logic-gate BIST sequencer and its environment.
interface logic_bist_if #(
  parameter int WIDTH = 1,
  parameter int ERR_W = 8
);
  logic             start;
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic [1:0]       dut_op;
  logic [WIDTH-1:0] dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [15:0]      first_fail;

  modport master (
    input  start, dut_y,
    output dut_a, dut_b, dut_op, busy, done, pass, err_count, first_fail
  );

  modport slave (
    output start, dut_y,
    input  dut_a, dut_b, dut_op, busy, done, pass, err_count, first_fail
  );
endinterface

// File: rtl/logic_bist_ctrl.sv
// BIST sequencer for 2-input AND/OR/XOR/XNOR gates: drives vectors, compares against a golden model.
// Define BIST_LFSR_EN to source vectors from a seeded LFSR (NUM_VEC per run) instead of an exhaustive counter.
module logic_bist_ctrl #(
  parameter int WIDTH      = 1,
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 8,
  parameter int NUM_VEC    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  logic_bist_if.master  bus
);

  localparam int VW = 2 + 2 * WIDTH;
`ifdef BIST_LFSR_EN
  localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);
  localparam logic [VW-1:0] TAPS = (VW == 4) ? VW'(4'b1100)      :
                                   (VW == 6) ? VW'(6'b110000)    :
                                   (VW == 8) ? VW'(8'b10111000)  :
                                               VW'(10'b1001000000);
  localparam logic [VW-1:0] SEED = VW'(1);
`else
  localparam logic [15:0] LAST_IDX = 16'((4 << (2 * WIDTH)) - 1);
`endif
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_APPLY  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Reset asserts immediately but releases only after two clean clock edges.
  logic [1:0] rstSync_q;
  logic       rstInt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstSync_q <= 2'b00;
    else        rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstInt_n = rstSync_q[1];

  logic [2:0]       state_q, state_d;
  logic [15:0]      vecIdx_q, vecIdx_d;
  logic [3:0]       settleCnt_q, settleCnt_d;
  logic [WIDTH-1:0] dutA_q, dutA_d, dutB_q, dutB_d;
  logic [1:0]       dutOp_q, dutOp_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0] errCount_q, errCount_d, errNext;
  logic [15:0]      firstFail_q, firstFail_d;
  logic [15:0]      idxInc;
  logic [VW-1:0]    startVec, stepVec, applyVec;
  logic             loadVec;
  logic [WIDTH-1:0] golden;
  logic             mismatch;

  assign idxInc = vecIdx_q + 16'd1;

`ifdef BIST_LFSR_EN
  logic [VW-1:0] lfsr_q, lfsr_d;

  function automatic logic [VW-1:0] lfsrStep(input logic [VW-1:0] s);
    return {s[VW-2:0], ^(s & TAPS)};
  endfunction

  assign startVec = SEED;
  assign stepVec  = lfsr_q;
`else
  assign startVec = '0;
  assign stepVec  = idxInc[VW-1:0];
`endif

  // Golden result is taken from the registered vector, so it is stable for the whole settle window.
  always_comb begin
    golden = '0;
    case (dutOp_q)
      2'd0:    golden = dutA_q & dutB_q;
      2'd1:    golden = dutA_q | dutB_q;
      2'd2:    golden = dutA_q ^ dutB_q;
      default: golden = ~(dutA_q ^ dutB_q);
    endcase
  end

  assign mismatch = (bus.dut_y != golden);

  always_comb begin
    state_d     = state_q;
    vecIdx_d    = vecIdx_q;
    settleCnt_d = settleCnt_q;
    dutA_d      = dutA_q;
    dutB_d      = dutB_q;
    dutOp_d     = dutOp_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    errCount_d  = errCount_q;
    firstFail_d = firstFail_q;
    errNext     = errCount_q;
    loadVec     = 1'b0;
    applyVec    = startVec;
`ifdef BIST_LFSR_EN
    lfsr_d      = lfsr_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d     = ST_APPLY;
          vecIdx_d    = '0;
          errCount_d  = '0;
          firstFail_d = 16'hFFFF;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          loadVec     = 1'b1;
          applyVec    = startVec;
`ifdef BIST_LFSR_EN
          lfsr_d      = lfsrStep(SEED);
`endif
        end
      end
      ST_APPLY: begin
        settleCnt_d = '0;
        state_d     = (SETTLE_CYC > 0) ? ST_WAIT : ST_SAMPLE;
      end
      ST_WAIT: begin
        if (settleCnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
        else                            settleCnt_d = settleCnt_q + 4'd1;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (errCount_q != '1)         errNext = errCount_q + 1'b1;
          if (firstFail_q == 16'hFFFF)  firstFail_d = vecIdx_q;
        end
        errCount_d = errNext;
        if (vecIdx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (errNext == '0);
        end else begin
          state_d  = ST_APPLY;
          vecIdx_d = idxInc;
          loadVec  = 1'b1;
          applyVec = stepVec;
`ifdef BIST_LFSR_EN
          lfsr_d   = lfsrStep(lfsr_q);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Operand fields follow the {op, a, b} packing with b in the least significant bits.
    if (loadVec) begin
      dutOp_d = applyVec[VW-1:2*WIDTH];
      dutA_d  = applyVec[2*WIDTH-1:WIDTH];
      dutB_d  = applyVec[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      state_q     <= ST_IDLE;
      vecIdx_q    <= '0;
      settleCnt_q <= '0;
      dutA_q      <= '0;
      dutB_q      <= '0;
      dutOp_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errCount_q  <= '0;
      firstFail_q <= 16'hFFFF;
`ifdef BIST_LFSR_EN
      lfsr_q      <= SEED;
`endif
    end else begin
      state_q     <= state_d;
      vecIdx_q    <= vecIdx_d;
      settleCnt_q <= settleCnt_d;
      dutA_q      <= dutA_d;
      dutB_q      <= dutB_d;
      dutOp_q     <= dutOp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      errCount_q  <= errCount_d;
      firstFail_q <= firstFail_d;
`ifdef BIST_LFSR_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign bus.dut_a      = dutA_q;
  assign bus.dut_b      = dutB_q;
  assign bus.dut_op     = dutOp_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = errCount_q;
  assign bus.first_fail = firstFail_q;

endmodule
